// File: rtl/bcd_display_scanner.sv
// bcd_display_scanner
//   Latches a two-digit packed BCD sum plus decimal carry and drives a
//   three-digit time-multiplexed 7-segment display (hundreds = carry, tens,
//   units). Each digit slot lasts REFRESH_DIV cycles. The first cycle of every
//   slot is blank to avoid ghosting. Leading zeros can be blanked, and
//   non-decimal nibbles are flagged.
//
// Ports
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   load      in   capture strobe for bcd_in / carry_in
//   bcd_in    in   [7:4] tens, [3:0] units (packed BCD)
//   carry_in  in   decimal carry-out, shown as hundreds "1"
//   blank_lz  in   suppress leading zeros (live, not latched)
//   seg       out  {g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW
//   an        out  an[0] units, an[1] tens, an[2] hundreds, polarity per AN_ACTIVE_LOW
//   err       out  latched value holds a nibble above 9
//
// Scan states
//   state      | meaning
//   S_UNITS    | units digit slot
//   S_TENS     | tens digit slot
//   S_HUNDREDS | hundreds (carry) digit slot

module bcd_display_scanner #(
  parameter int REFRESH_DIV    = 1000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] bcd_in,
  input  logic       carry_in,
  input  logic       blank_lz,
  output logic [6:0] seg,
  output logic [2:0] an,
  output logic       err
);

  localparam int               CNT_W    = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [6:0]       SEG_OFF  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [2:0]       AN_OFF   = AN_ACTIVE_LOW ? 3'b111 : 3'b000;

  typedef enum logic [1:0] {
    S_UNITS    = 2'd0,
    S_TENS     = 2'd1,
    S_HUNDREDS = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [8:0]       latch_q, latch_d;
  logic [6:0]       seg_q, seg_d;
  logic [2:0]       an_q, an_d;
  logic             err_q, err_d;

  logic [3:0]       digit;
  logic             lit;
  logic [2:0]       an_sel;
  logic [6:0]       seg_raw;
  logic [2:0]       an_raw;

  function automatic logic [6:0] encode(input logic [3:0] d);
    case (d)
      4'd0:    encode = 7'h3F;
      4'd1:    encode = 7'h06;
      4'd2:    encode = 7'h5B;
      4'd3:    encode = 7'h4F;
      4'd4:    encode = 7'h66;
      4'd5:    encode = 7'h6D;
      4'd6:    encode = 7'h7D;
      4'd7:    encode = 7'h07;
      4'd8:    encode = 7'h7F;
      4'd9:    encode = 7'h6F;
      default: encode = 7'h79;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_UNITS;
      cnt_q   <= '0;
      latch_q <= '0;
      seg_q   <= SEG_OFF;
      an_q    <= AN_OFF;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      latch_q <= latch_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
      err_q   <= err_d;
    end
  end

  // Outputs are computed from the next-cycle state so the registered display
  // lines up with the counter: cnt_q == 0 is always the blank cycle, and a
  // load is visible on the very next output cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    latch_d = latch_q;
    digit   = 4'd0;
    lit     = 1'b1;
    an_sel  = 3'b000;
    seg_raw = 7'h00;
    an_raw  = 3'b000;

    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      case (state_q)
        S_UNITS: state_d = S_TENS;
        S_TENS:  state_d = S_HUNDREDS;
        default: state_d = S_UNITS;
      endcase
    end

    if (load) latch_d = {carry_in, bcd_in};

    err_d = (latch_d[3:0] > 4'd9) || (latch_d[7:4] > 4'd9);

    case (state_d)
      S_UNITS: begin
        digit  = latch_d[3:0];
        an_sel = 3'b001;
      end
      S_TENS: begin
        digit  = latch_d[7:4];
        lit    = !(blank_lz && !latch_d[8] && (latch_d[7:4] == 4'd0));
        an_sel = 3'b010;
      end
      default: begin
        digit  = {3'b000, latch_d[8]};
        lit    = !(blank_lz && !latch_d[8]);
        an_sel = 3'b100;
      end
    endcase

    if ((cnt_d != '0) && lit) begin
      seg_raw = encode(digit);
      an_raw  = an_sel;
    end

    seg_d = SEG_ACTIVE_LOW ? ~seg_raw : seg_raw;
    an_d  = AN_ACTIVE_LOW ? ~an_raw : an_raw;
  end

  assign seg = seg_q;
  assign an  = an_q;
  assign err = err_q;

endmodule

// File: tb/tb_bcd_display_scanner.sv
module tb_bcd_display_scanner;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load;
  logic [7:0] bcd_in;
  logic       carry_in;
  logic       blank_lz;

  logic [6:0] seg0, seg1;
  logic [2:0] an0, an1;
  logic       err0, err1;

  int checks = 0;
  int errors = 0;

  // Reference model state: cycles since reset release, latched value, sampled blank_lz.
  int         m_t;
  logic [7:0] m_val;
  logic       m_carry;
  logic       m_blz;

  logic [6:0] seg_tab [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  logic [21:0] exp_v;
  wire  [21:0] obs = {seg0, an0, err0, seg1, an1, err1};

  always #5 clk = ~clk;

  bcd_display_scanner #(.REFRESH_DIV(N), .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .load(load), .bcd_in(bcd_in), .carry_in(carry_in),
    .blank_lz(blank_lz), .seg(seg0), .an(an0), .err(err0));

  bcd_display_scanner #(.REFRESH_DIV(N)) dut1 (
    .clk(clk), .rst_n(rst_n), .load(load), .bcd_in(bcd_in), .carry_in(carry_in),
    .blank_lz(blank_lz), .seg(seg1), .an(an1), .err(err1));

  function automatic logic [6:0] seg_of(input int d);
    return (d > 9) ? 7'h79 : seg_tab[d];
  endfunction

  function automatic int m_slot();
    return (m_t / N) % 3;
  endfunction

  function automatic int m_pos();
    return m_t % N;
  endfunction

  // Expected {seg,an,err} for the active-high DUT followed by the inverted DUT.
  function automatic logic [21:0] model_exp();
    int tens, units, slot, digit;
    logic lit, e;
    logic [6:0] s;
    logic [2:0] a;
    tens  = int'(m_val[7:4]);
    units = int'(m_val[3:0]);
    slot  = m_slot();
    e     = (tens > 9) || (units > 9);
    case (slot)
      0: begin digit = units; lit = 1'b1; end
      1: begin digit = tens;  lit = !(m_blz && !m_carry && tens == 0); end
      default: begin digit = m_carry ? 1 : 0; lit = !(m_blz && !m_carry); end
    endcase
    if (m_pos() == 0 || !lit) begin
      s = 7'h00;
      a = 3'b000;
    end else begin
      s = seg_of(digit);
      a = 3'(1 << slot);
    end
    return {s, a, e, ~s, ~a, e};
  endfunction

  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      m_t = 0; m_val = 8'h00; m_carry = 1'b0;
    end else begin
      m_t++;
      if (load) {m_carry, m_val} = {carry_in, bcd_in};
      m_blz = blank_lz;
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; load = 1'b0; bcd_in = 8'h00; carry_in = 1'b0; blank_lz = 1'b0;
    m_t = 0; m_val = 8'h00; m_carry = 1'b0; m_blz = 1'b0;
    #2;
    tick(); tick();
    exp_v = model_exp();
    checks++;
    if (obs !== exp_v) begin
      errors++; $display("FAIL reset obs=%h exp=%h", obs, exp_v);
    end
    checks++;
    if ({seg1, an1, err1} !== {7'h7F, 3'b111, 1'b0}) begin
      errors++; $display("FAIL reset_pol seg=%h an=%b err=%b required 7f/111/0", seg1, an1, err1);
    end
  endtask

  task automatic test_scan_47();
    load = 1'b1; bcd_in = 8'h47; carry_in = 1'b1; blank_lz = 1'b0;
    rst_n = 1'b1;
    #1;
    exp_v = model_exp();
    checks++;
    if (obs !== exp_v) begin
      errors++; $display("FAIL scan47_blank obs=%h exp=%h", obs, exp_v);
    end
    tick();
    load = 1'b0;
    checks++;
    if ({an0, seg0} !== {3'b001, 7'h07}) begin
      errors++; $display("FAIL scan47_first an=%b seg=%h required 001/07", an0, seg0);
    end
    for (int i = 0; i < 4 * N; i++) begin
      tick();
      exp_v = model_exp();
      checks++;
      if (obs !== exp_v) begin
        errors++; $display("FAIL scan47 t=%0d obs=%h exp=%h", m_t, obs, exp_v);
      end
    end
  endtask

  task automatic test_lz_05();
    load = 1'b1; bcd_in = 8'h05; carry_in = 1'b0; blank_lz = 1'b1;
    tick();
    load = 1'b0;
    for (int i = 0; i < 6 * N; i++) begin
      exp_v = model_exp();
      checks++;
      if (obs !== exp_v) begin
        errors++; $display("FAIL lz05 t=%0d obs=%h exp=%h", m_t, obs, exp_v);
      end
      tick();
    end
  endtask

  task automatic test_lz_00();
    load = 1'b1; bcd_in = 8'h00; carry_in = 1'b0; blank_lz = 1'b1;
    tick();
    load = 1'b0;
    for (int i = 0; i < 6 * N; i++) begin
      if (i == 3 * N) blank_lz = 1'b0;
      exp_v = model_exp();
      checks++;
      if (obs !== exp_v) begin
        errors++; $display("FAIL lz00 t=%0d blz=%b obs=%h exp=%h", m_t, m_blz, obs, exp_v);
      end
      tick();
    end
  endtask

  task automatic test_err();
    load = 1'b1; bcd_in = 8'hA3; carry_in = 1'b0; blank_lz = 1'b0;
    tick();
    load = 1'b0;
    checks++;
    if (err0 !== 1'b1) begin
      errors++; $display("FAIL err_set err=%b required 1", err0);
    end
    for (int i = 0; i < 3 * N; i++) begin
      tick();
      exp_v = model_exp();
      checks++;
      if (obs !== exp_v) begin
        errors++; $display("FAIL errA3 t=%0d obs=%h exp=%h", m_t, obs, exp_v);
      end
    end
    load = 1'b1; bcd_in = 8'h12;
    tick();
    load = 1'b0;
    checks++;
    if (err0 !== 1'b0) begin
      errors++; $display("FAIL err_clear err=%b required 0", err0);
    end
  endtask

  task automatic test_load_mid_tens();
    int lit_cycles = 0;
    for (int i = 0; i < 3 * N; i++) begin
      if (m_slot() == 1 && m_pos() == 0) break;
      tick();
    end
    for (int p = 1; p < N; p++) begin
      if (p == 2) begin load = 1'b1; bcd_in = 8'h68; carry_in = 1'b0; end
      tick();
      load = 1'b0;
      if (an0 === 3'b010) lit_cycles++;
      exp_v = model_exp();
      checks++;
      if (obs !== exp_v) begin
        errors++; $display("FAIL midtens t=%0d obs=%h exp=%h", m_t, obs, exp_v);
      end
    end
    tick();
    exp_v = model_exp();
    checks++;
    if (obs !== exp_v) begin
      errors++; $display("FAIL midtens_next t=%0d obs=%h exp=%h", m_t, obs, exp_v);
    end
    checks++;
    if (lit_cycles !== N - 1) begin
      errors++; $display("FAIL midtens_len lit=%0d required %0d", lit_cycles, N - 1);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3 * N; i++) begin
      if (m_slot() == 2 && m_pos() == 2) break;
      tick();
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({seg0, an0, err0, seg1, an1, err1} !== {7'h00, 3'b000, 1'b0, 7'h7F, 3'b111, 1'b0}) begin
      errors++; $display("FAIL async_rst obs=%h", obs);
    end
    tick(); tick();
    rst_n = 1'b1;
    #1;
    exp_v = model_exp();
    checks++;
    if (obs !== exp_v) begin
      errors++; $display("FAIL rst_release obs=%h exp=%h", obs, exp_v);
    end
    tick();
    checks++;
    if ({an0, seg0} !== {3'b001, 7'h3F}) begin
      errors++; $display("FAIL rst_units an=%b seg=%h required 001/3f", an0, seg0);
    end
  endtask

  task automatic test_polarity_8();
    load = 1'b1; bcd_in = 8'h08; carry_in = 1'b0; blank_lz = 1'b0;
    tick();
    load = 1'b0;
    for (int i = 0; i < 3 * N; i++) begin
      if (m_slot() == 0 && m_pos() == 0) break;
      tick();
    end
    checks++;
    if ({seg1, an1} !== {7'h7F, 3'b111}) begin
      errors++; $display("FAIL pol_blank seg=%h an=%b required 7f/111", seg1, an1);
    end
    tick();
    checks++;
    if ({seg1, an1} !== {7'h00, 3'b110}) begin
      errors++; $display("FAIL pol_lit seg=%h an=%b required 00/110", seg1, an1);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      load     = ($urandom_range(0, 3) == 0);
      bcd_in   = ($urandom_range(0, 4) == 0) ? 8'($urandom)
                 : {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      carry_in = 1'($urandom);
      if ($urandom_range(0, 15) == 0) blank_lz = ~blank_lz;
      tick();
      exp_v = model_exp();
      checks++;
      if (obs !== exp_v) begin
        errors++; $display("FAIL random t=%0d val=%h c=%b blz=%b obs=%h exp=%h",
                           m_t, m_val, m_carry, m_blz, obs, exp_v);
      end
    end
    load = 1'b0;
  endtask

  initial begin
    test_reset();
    test_scan_47();
    test_lz_05();
    test_lz_00();
    test_err();
    test_load_mid_tens();
    test_async_reset();
    test_polarity_8();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_display_scanner.md
Name: bcd_display_scanner

Overview:
- Downstream consumer of the team's two-digit BCD adder result: latches the 8-bit packed BCD sum plus decimal carry-out and drives a 3-digit time-multiplexed 7-segment display (hundreds = carry, tens, units).
- Contains a refresh divider, a digit-scan state machine with an anti-ghosting blank cycle at every digit switch, optional leading-zero blanking, and invalid-digit detection.
- All display outputs are registered.

Parameters:
- REFRESH_DIV, 1000: clock cycles per digit slot. Legal range is 2 or more; counter width is $clog2(REFRESH_DIV).
- SEG_ACTIVE_LOW, 1: 1 means segment outputs are inverted (lit = 0).
- AN_ACTIVE_LOW, 1: 1 means digit-enable outputs are inverted (enabled = 0).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- load  input  1  single-cycle strobe; capture bcd_in and carry_in this cycle.
- bcd_in  input  8  packed BCD value: [7:4] tens, [3:0] units.
- carry_in  input  1  decimal carry-out; shown as hundreds digit "1".
- blank_lz  input  1  1 = suppress leading zeros. Sampled every cycle (not latched).
- seg  output  7  segment pattern {g,f,e,d,c,b,a}.
- an  output  3  digit enables: an[0] units, an[1] tens, an[2] hundreds.
- err  output  1  latched value contains a nibble greater than 9.

Behaviour:
- Reset (asynchronous, while rst_n=0):
  - Latch register (value, carry) = 0; refresh counter = 0; digit index = 0.
  - an = all inactive; seg = all off (polarity per parameters); err = 0.
- Capture:
  - On a clk edge with load=1, the latch takes {carry_in, bcd_in}. The next output cycle uses the new value.
  - err updates on the same edge.
  - load does not restart or disturb the scan counter or digit index.
  - load held high re-captures on every cycle.
- Refresh counter:
  - Counts 0 to REFRESH_DIV-1, then wraps to 0.
  - On wrap, the digit index advances 0→1→2→0.
- Scan FSM:
  - States are UNITS, TENS, HUNDREDS, cycling in that order with no other transitions.
  - Each state lasts exactly REFRESH_DIV output cycles.
- Blanking:
  - The first output cycle of every slot drives all an inactive and seg off.
  - The remaining REFRESH_DIV-1 cycles assert only that slot's an bit.
  - At most one an bit is ever active.
- Start-up: the first output cycle after rst_n deasserts is the blank cycle of the UNITS slot.
- Digit source:
  - UNITS = latched [3:0].
  - TENS = latched [7:4].
  - HUNDREDS = "1" if latched carry=1, else "0".
- Leading-zero blanking (blank_lz=1):
  - HUNDREDS is blanked when carry=0.
  - TENS is blanked when carry=0 and tens=0.
  - UNITS is never blanked.
  - A blanked digit keeps its an bit inactive for the whole slot; the slot timing is unchanged.
- Encoding (active-high, before polarity inversion):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Any nibble in A–F displays "E" = 79 and sets err.
- Error flag:
  - err = (latched[3:0] > 9) OR (latched[7:4] > 9).
  - err stays set until the next load of a valid value or reset.
- Asynchronous reset mid-scan: everything returns to reset values immediately. After release, scanning restarts at the UNITS blank cycle.

Test Plan:
- REFRESH_DIV=4, both polarities 0. Reset, then load bcd_in=8'h47, carry_in=1, blank_lz=0.
  - Required sequence: 1 blank cycle, then an=001 / seg=07 for 3 cycles; 1 blank cycle, then an=010 / seg=66 for 3 cycles; 1 blank cycle, then an=100 / seg=06 for 3 cycles; then wrap to UNITS.
- Load 8'h05, carry_in=0, blank_lz=1 → UNITS shows seg=6D; TENS and HUNDREDS slots keep an=000 for their full 4 cycles; err=0.
- Load 8'h00, carry_in=0, blank_lz=1 → only UNITS lit with seg=3F. Toggle blank_lz to 0 → TENS and HUNDREDS show 3F.
- Load 8'hA3 → err=1 on the cycle after load; TENS slot shows seg=79. Then load 8'h12 → err=0 on the next cycle.
- Load pulses in the middle of a TENS slot → the slot length is unchanged (still 4 cycles), and the new tens pattern appears on the next output cycle.
- Assert rst_n=0 for 2 cycles during the HUNDREDS slot → an and seg go inactive immediately (asynchronously) and the latch is cleared. After release, a UNITS blank cycle is followed by seg=3F.
- Default polarities (SEG_ACTIVE_LOW=1, AN_ACTIVE_LOW=1) with digit 8 → seg=7'h00 and an=3'b110 during the UNITS slot; blank cycles show seg=7F and an=111.
